// File: rtl/fp_sub_share_arbiter.sv
// Round-robin arbiter sharing one HLS subFloat64Sigs core (ap_start/ap_ready/ap_done)
// among NREQ lanes; operands are frozen at grant and the result is returned with a done pulse.
module fp_sub_share_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 64,
    parameter int unsigned IDW  = 2
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   req_a,
    input  logic [NREQ*DW-1:0]   req_b,
    input  logic [NREQ-1:0]      req_zsign,
    output logic [NREQ-1:0]      grant,
    output logic [NREQ-1:0]      done,
    output logic [DW-1:0]        result,
    output logic [IDW-1:0]       rsp_id,
    output logic                 busy,
    output logic                 core_start,
    output logic [DW-1:0]        core_a,
    output logic [DW-1:0]        core_b,
    output logic                 core_zsign,
    input  logic                 core_ready,
    input  logic                 core_done,
    input  logic [DW-1:0]        core_return
);

    typedef enum logic [3:0] {
        StIdle  = 4'b0001,
        StIssue = 4'b0010,
        StWait  = 4'b0100,
        StResp  = 4'b1000
    } state_t;

    state_t         state_q;
    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] win_id;
    logic           win_valid;

    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] id);
        if (32'(id) >= NREQ - 1) begin
            return '0;
        end
        return id + IDW'(1);
    endfunction

    // First requesting lane at or after ptr_q, wrapping past NREQ-1.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        win_valid = 1'b0;
        win_id    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(ptr_q) + k) % NREQ;
            if (!win_valid && req[idx]) begin
                win_valid = 1'b1;
                win_id    = IDW'(idx);
            end
        end
    end

    assign busy = (state_q != StIdle);

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            grant      <= '0;
            done       <= '0;
            result     <= '0;
            rsp_id     <= '0;
            core_start <= 1'b0;
            core_a     <= '0;
            core_b     <= '0;
            core_zsign <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done <= '0;
                    if (win_valid) begin
                        core_a     <= req_a[win_id*DW +: DW];
                        core_b     <= req_b[win_id*DW +: DW];
                        core_zsign <= req_zsign[win_id];
                        rsp_id     <= win_id;
                        grant      <= NREQ'(1) << win_id;
                        core_start <= 1'b1;
                        state_q    <= StIssue;
                    end
                end
                StIssue: begin
                    // Start is held until the core accepts; done may coincide with ready.
                    if (core_ready) begin
                        core_start <= 1'b0;
                        if (core_done) begin
                            result  <= core_return;
                            done    <= NREQ'(1) << rsp_id;
                            state_q <= StResp;
                        end else begin
                            state_q <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (core_done) begin
                        result  <= core_return;
                        done    <= NREQ'(1) << rsp_id;
                        state_q <= StResp;
                    end
                end
                StResp: begin
                    done    <= '0;
                    grant   <= '0;
                    ptr_q   <= wrap_inc(rsp_id);
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_sub_share_arbiter.sv
// Bench for fp_sub_share_arbiter: a behavioural core with programmable ready/done latency
// and a scoreboard of expected lane/result pairs compared at each done pulse.
module tb_fp_sub_share_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 64;
    localparam int IDW  = 2;

    logic              ap_clk = 1'b0;
    logic              ap_rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*DW-1:0] req_a;
    logic [NREQ*DW-1:0] req_b;
    logic [NREQ-1:0]   req_zsign;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   done;
    logic [DW-1:0]     result;
    logic [IDW-1:0]    rsp_id;
    logic              busy;
    logic              core_start;
    logic [DW-1:0]     core_a;
    logic [DW-1:0]     core_b;
    logic              core_zsign;
    logic              core_ready;
    logic              core_done;
    logic [DW-1:0]     core_return;

    int total = 0;
    int bad   = 0;

    int   rdy_lat  = 0;
    int   done_lat = 0;
    int   s_cnt    = 0;
    int   d_cnt    = 0;
    logic pending  = 1'b0;

    int          exp_lane_q[$];
    logic [63:0] exp_res_q[$];

    fp_sub_share_arbiter #(.NREQ(NREQ), .DW(DW), .IDW(IDW)) dut (
        .ap_clk     (ap_clk),
        .ap_rst     (ap_rst),
        .req        (req),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_zsign  (req_zsign),
        .grant      (grant),
        .done       (done),
        .result     (result),
        .rsp_id     (rsp_id),
        .busy       (busy),
        .core_start (core_start),
        .core_a     (core_a),
        .core_b     (core_b),
        .core_zsign (core_zsign),
        .core_ready (core_ready),
        .core_done  (core_done),
        .core_return(core_return)
    );

    always #5 ap_clk = ~ap_clk;

    function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                          input logic z);
        return (a - b) ^ {z, 63'b0};
    endfunction

    // Core model: ready after rdy_lat stalled cycles, done done_lat cycles after ready.
    always @(posedge ap_clk) begin
        if (ap_rst) begin
            s_cnt   <= 0;
            d_cnt   <= 0;
            pending <= 1'b0;
        end else begin
            if (core_start && !core_ready) s_cnt <= s_cnt + 1;
            else s_cnt <= 0;
            if (core_ready && !core_done) begin
                pending <= 1'b1;
                d_cnt   <= 1;
            end else if (pending && core_done) begin
                pending <= 1'b0;
                d_cnt   <= 0;
            end else if (pending) begin
                d_cnt <= d_cnt + 1;
            end
        end
    end

    assign core_ready  = core_start && (s_cnt == rdy_lat);
    assign core_done   = (core_ready && done_lat == 0) || (pending && d_cnt == done_lat);
    assign core_return = model(core_a, core_b, core_zsign);

    task automatic set_lane(input int i);
        req_a[i*DW +: DW] = {$urandom, $urandom};
        req_b[i*DW +: DW] = {$urandom, $urandom};
        req_zsign[i]      = 1'($urandom_range(0, 1));
    endtask

    task automatic push_exp(input int i);
        exp_lane_q.push_back(i);
        exp_res_q.push_back(model(req_a[i*DW +: DW], req_b[i*DW +: DW], req_zsign[i]));
    endtask

    // Returns lane -1 on timeout, -2 if done was not one-hot.
    task automatic wait_done(input int budget, output int lane, output logic [63:0] res,
                             output int waited, output int idle);
        lane = -1; res = '0; waited = 0; idle = 0;
        while (waited < budget) begin
            @(negedge ap_clk);
            waited++;
            if (busy === 1'b0) idle++;
            if (done !== '0) begin
                if (!$onehot(done)) lane = -2;
                else for (int i = 0; i < NREQ; i++) if (done[i]) lane = i;
                res = result;
                break;
            end
        end
    endtask

    task automatic test_reset();
        ap_rst = 1'b1; req = '0; req_a = '0; req_b = '0; req_zsign = '0;
        repeat (2) @(negedge ap_clk);
        total++;
        if ({grant, done, rsp_id, busy, core_start, core_zsign} !== '0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 0",
                     {grant, done, rsp_id, busy, core_start, core_zsign});
        end
        total++;
        if ({result, core_a, core_b} !== '0) begin
            bad++;
            $display("FAIL reset_data: got %h/%h/%h want 0", result, core_a, core_b);
        end
        ap_rst = 1'b0;
        @(negedge ap_clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle: busy got %b want 0", busy); end
    endtask

    task automatic test_round_robin();
        int lane, waited, idle;
        logic [63:0] res;
        rdy_lat = 0; done_lat = 0;
        for (int i = 0; i < NREQ; i++) set_lane(i);
        push_exp(0); push_exp(1); push_exp(2); push_exp(3); push_exp(0);
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            wait_done(20, lane, res, waited, idle);
            if (n == 4) req = '0;
            total++;
            if (lane !== exp_lane_q[0]) begin
                bad++; $display("FAIL rr_lane%0d: got %0d want %0d", n, lane, exp_lane_q[0]);
            end
            total++;
            if (res !== exp_res_q[0]) begin
                bad++; $display("FAIL rr_result%0d: got %h want %h", n, res, exp_res_q[0]);
            end
            if (n > 0) begin
                total++;
                if (idle !== 1) begin
                    bad++; $display("FAIL rr_idle%0d: got %0d want 1", n, idle);
                end
            end
            void'(exp_lane_q.pop_front()); void'(exp_res_q.pop_front());
        end
        repeat (3) @(negedge ap_clk);
    endtask

    task automatic test_single();
        int lane, waited, idle;
        logic [63:0] res;
        rdy_lat = 0; done_lat = 6;
        set_lane(2); push_exp(2);
        req = 4'b0100;
        @(negedge ap_clk);
        total++;
        if ({core_start, grant, rsp_id} !== {1'b1, 4'b0100, 2'd2}) begin
            bad++; $display("FAIL single_issue: got %b want 1010010", {core_start, grant, rsp_id});
        end
        total++;
        if (core_a !== req_a[2*DW +: DW]) begin
            bad++; $display("FAIL single_opa: got %h want %h", core_a, req_a[2*DW +: DW]);
        end
        @(negedge ap_clk);
        total++;
        if (core_start !== 1'b0) begin
            bad++; $display("FAIL single_start_len: got %b want 0", core_start);
        end
        wait_done(20, lane, res, waited, idle);
        req = '0;
        // done lands 8 cycles after the request was sampled; 2 already elapsed above.
        total++;
        if (waited !== 6) begin bad++; $display("FAIL single_latency: got %0d want 6", waited); end
        total++;
        if (lane !== exp_lane_q[0]) begin
            bad++; $display("FAIL single_lane: got %0d want %0d", lane, exp_lane_q[0]);
        end
        total++;
        if (res !== exp_res_q[0]) begin
            bad++; $display("FAIL single_result: got %h want %h", res, exp_res_q[0]);
        end
        void'(exp_lane_q.pop_front()); void'(exp_res_q.pop_front());
        @(negedge ap_clk);
        total++;
        if ({done, busy} !== 5'b0) begin
            bad++; $display("FAIL single_after: got %b want 0", {done, busy});
        end
        repeat (2) @(negedge ap_clk);
    endtask

    task automatic test_wrap();
        int lane, waited, idle;
        logic [63:0] res;
        rdy_lat = 1; done_lat = 2;
        set_lane(0); set_lane(3);
        push_exp(3); push_exp(0);
        req = 4'b1001;
        for (int n = 0; n < 2; n++) begin
            wait_done(20, lane, res, waited, idle);
            if (lane >= 0) req[lane] = 1'b0;
            total++;
            if (lane !== exp_lane_q[0]) begin
                bad++; $display("FAIL wrap_lane%0d: got %0d want %0d", n, lane, exp_lane_q[0]);
            end
            total++;
            if (res !== exp_res_q[0]) begin
                bad++; $display("FAIL wrap_result%0d: got %h want %h", n, res, exp_res_q[0]);
            end
            void'(exp_lane_q.pop_front()); void'(exp_res_q.pop_front());
        end
        req = '0;
        repeat (3) @(negedge ap_clk);
    endtask

    task automatic test_same_cycle();
        int lane, waited, idle;
        logic [63:0] res;
        rdy_lat = 0; done_lat = 0;
        set_lane(1); push_exp(1);
        req = 4'b0010;
        @(negedge ap_clk);
        total++;
        if ({core_start, busy} !== 2'b11) begin
            bad++; $display("FAIL fast_issue: got %b want 11", {core_start, busy});
        end
        wait_done(10, lane, res, waited, idle);
        req = '0;
        total++;
        if (waited !== 1) begin bad++; $display("FAIL fast_latency: got %0d want 1", waited); end
        total++;
        if (lane !== exp_lane_q[0] || res !== exp_res_q[0]) begin
            bad++; $display("FAIL fast_resp: got %0d/%h want %0d/%h", lane, res,
                            exp_lane_q[0], exp_res_q[0]);
        end
        void'(exp_lane_q.pop_front()); void'(exp_res_q.pop_front());
        repeat (3) @(negedge ap_clk);
    endtask

    task automatic test_ready_stall();
        int lane, waited, idle, stall;
        logic [63:0] res, a0, b0;
        rdy_lat = 4; done_lat = 2;
        set_lane(2); push_exp(2);
        req = 4'b0100;
        @(negedge ap_clk);
        a0 = core_a; b0 = core_b;
        req_a[2*DW +: DW] = ~req_a[2*DW +: DW];
        req_b[2*DW +: DW] = req_b[2*DW +: DW] + 64'd77;
        req_zsign[2] = ~req_zsign[2];
        stall = 0;
        for (int c = 0; c < 12 && core_start === 1'b1; c++) begin
            if (!core_ready) stall++;
            total++;
            if (core_a !== a0 || core_b !== b0) begin
                bad++; $display("FAIL stall_operands%0d: got %h/%h want %h/%h",
                                c, core_a, core_b, a0, b0);
            end
            @(negedge ap_clk);
        end
        total++;
        if (stall !== 4) begin bad++; $display("FAIL stall_start_len: got %0d want 4", stall); end
        wait_done(20, lane, res, waited, idle);
        req = '0;
        total++;
        if (lane !== exp_lane_q[0] || res !== exp_res_q[0]) begin
            bad++; $display("FAIL stall_resp: got %0d/%h want %0d/%h", lane, res,
                            exp_lane_q[0], exp_res_q[0]);
        end
        void'(exp_lane_q.pop_front()); void'(exp_res_q.pop_front());
        repeat (3) @(negedge ap_clk);
    endtask

    task automatic test_reset_mid();
        int lane, waited, idle, spurious;
        logic [63:0] res;
        rdy_lat = 0; done_lat = 10;
        set_lane(3);
        req = 4'b1000;
        repeat (4) @(negedge ap_clk);
        total++;
        if ({busy, core_start} !== 2'b10) begin
            bad++; $display("FAIL mid_in_wait: got %b want 10", {busy, core_start});
        end
        ap_rst = 1'b1; req = '0;
        @(negedge ap_clk);
        total++;
        if ({grant, done, rsp_id, busy, core_start, core_zsign, result, core_a, core_b} !== '0)
        begin
            bad++; $display("FAIL mid_reset_outputs: grant=%b busy=%b start=%b res=%h",
                            grant, busy, core_start, result);
        end
        ap_rst = 1'b0;
        spurious = 0;
        repeat (15) begin
            @(negedge ap_clk);
            if (done !== '0) spurious++;
        end
        total++;
        if (spurious !== 0) begin bad++; $display("FAIL mid_no_done: got %0d want 0", spurious); end
        // ptr restarts at 0, so lane 0 wins over lane 3.
        set_lane(0); set_lane(3); push_exp(0);
        rdy_lat = 1; done_lat = 1;
        req = 4'b1001;
        wait_done(20, lane, res, waited, idle);
        req = '0;
        total++;
        if (lane !== exp_lane_q[0] || res !== exp_res_q[0]) begin
            bad++; $display("FAIL mid_after_reset: got %0d/%h want %0d/%h", lane, res,
                            exp_lane_q[0], exp_res_q[0]);
        end
        void'(exp_lane_q.pop_front()); void'(exp_res_q.pop_front());
        repeat (3) @(negedge ap_clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_wrap();
        test_same_cycle();
        test_ready_stall();
        test_reset_mid();
        total++;
        if (exp_lane_q.size() != 0) begin
            bad++; $display("FAIL scoreboard_drain: got %0d want 0", exp_lane_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
